// File: rtl/bt656_data_decoder_if.sv
// ---------------------------------------------------------------------------
// bt656_data_decoder_if
//   Byte-stream handshake between the BT.656 data decoder output FIFO and
//   its consumer (the Ethernet TX path).
//
//   data_out   [7:0]  head of the FIFO; meaningful only while data_valid=1
//   data_valid        FIFO is non-empty
//   data_ready        consumer takes data_out on a cycle with valid && ready
//
//   master : producer side (the decoder)
//   slave  : consumer side
// ---------------------------------------------------------------------------
interface bt656_data_decoder_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/bt656_data_decoder.sv
// ---------------------------------------------------------------------------
// bt656_data_decoder
//   Recovers the datatape byte stream carried in the luma of a BT.656 video
//   stream. Timing codes (FF 00 00 XY) are parsed; after an active-line SAV
//   the Y samples are sliced into 2-bit symbols, packed MSB-first into bytes
//   and pushed through a small show-ahead FIFO.
//
// Ports
//   clk          27 MHz TD_CLK27, sole clock
//   rst          synchronous active-high reset
//   td_data      BT.656 byte stream
//   out_if       master side of bt656_data_decoder_if (data_out/valid/ready)
//   frame_start  one-cycle pulse on the first V=0 SAV after a V=1 code
//   overflow     sticky, set when a completed byte meets a full FIFO
//   err_count    saturating count of timing codes with bad protection bits
//
// Build option
//   BT656_ERR_COUNT_EN  defined: err_count counter is built.
//                       undefined: err_count is tied to 0 (bad codes still
//                       send the parser back to HUNT).
//
// Pipeline (Y sample sampled at edge 0):
//   edge 0: parser registers the sliced symbol and whether it ends a byte
//   edge 1: packer registers the completed byte as a FIFO write strobe
//   edge 2: FIFO write; data_valid rises after this edge on an empty FIFO
// ---------------------------------------------------------------------------
module bt656_data_decoder #(
  parameter int         GUARD_SAMPLES  = 8,
  parameter int         BYTES_PER_LINE = 176,
  parameter logic [7:0] THRESH_1       = 8'd52,
  parameter logic [7:0] THRESH_2       = 8'd124,
  parameter logic [7:0] THRESH_3       = 8'd196,
  parameter int         FIFO_DEPTH     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  td_data,
  bt656_data_decoder_if.master        out_if,
  output logic                        frame_start,
  output logic                        overflow,
  output logic [15:0]                 err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GUARD_SAMPLES > 0) ? $clog2(GUARD_SAMPLES + 1) : 1;
  localparam int BW = $clog2(BYTES_PER_LINE + 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_C1,
    S_C2,
    S_XY,
    S_ACTIVE
  } state_t;

  // -------------------------------------------------------------------------
  // Timing-code decode of the current byte (used while in S_XY)
  // -------------------------------------------------------------------------
  logic xy_f, xy_v, xy_h, xy_ok;
  assign xy_f  = td_data[6];
  assign xy_v  = td_data[5];
  assign xy_h  = td_data[4];
  assign xy_ok = td_data[7]
               & (td_data[3] == (xy_v ^ xy_h))
               & (td_data[2] == (xy_f ^ xy_h))
               & (td_data[1] == (xy_f ^ xy_v))
               & (td_data[0] == (xy_f ^ xy_v ^ xy_h));

  // -------------------------------------------------------------------------
  // Slicer (combinational; the result is registered by the parser)
  // -------------------------------------------------------------------------
  logic [1:0] slice_d;
  always_comb begin
    slice_d = 2'b11;
    if (td_data < THRESH_1)      slice_d = 2'b00;
    else if (td_data < THRESH_2) slice_d = 2'b01;
    else if (td_data < THRESH_3) slice_d = 2'b10;
  end

  // -------------------------------------------------------------------------
  // Parser FSM
  // -------------------------------------------------------------------------
  state_t          state_q;
  logic [1:0]      phase_q;
  logic [GW-1:0]   guard_q;
  logic [1:0]      sym_cnt_q;
  logic [BW-1:0]   byte_cnt_q;
  logic [1:0]      sym_q;
  logic            sym_valid_q;
  logic            sym_last_q;
  logic            seen_v1_q;
  logic            frame_start_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_HUNT;
      phase_q       <= 2'd0;
      guard_q       <= '0;
      sym_cnt_q     <= 2'd0;
      byte_cnt_q    <= '0;
      sym_q         <= 2'd0;
      sym_valid_q   <= 1'b0;
      sym_last_q    <= 1'b0;
      seen_v1_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      sym_valid_q   <= 1'b0;
      sym_last_q    <= 1'b0;
      frame_start_q <= 1'b0;
      case (state_q)
        S_HUNT: begin
          if (td_data == 8'hFF) state_q <= S_C1;
        end
        S_C1: begin
          state_q <= (td_data == 8'h00) ? S_C2 : S_HUNT;
        end
        S_C2: begin
          state_q <= (td_data == 8'h00) ? S_XY : S_HUNT;
        end
        S_XY: begin
          state_q <= S_HUNT;
          if (xy_ok) begin
            if (xy_v) begin
              seen_v1_q <= 1'b1;
            end else if (!xy_h) begin
              // Active-line SAV: start a fresh line.
              frame_start_q <= seen_v1_q;
              seen_v1_q     <= 1'b0;
              state_q       <= S_ACTIVE;
              phase_q       <= 2'd0;
              guard_q       <= '0;
              sym_cnt_q     <= 2'd0;
              byte_cnt_q    <= '0;
            end
          end
        end
        S_ACTIVE: begin
          if (td_data == 8'hFF) begin
            // Start of EAV: drop any partial byte. A symbol already in the
            // packer that completes a byte still gets written.
            state_q   <= S_C1;
            sym_cnt_q <= 2'd0;
          end else begin
            phase_q <= phase_q + 2'd1;
            if (phase_q[0]) begin
              if (guard_q != GW'(GUARD_SAMPLES)) begin
                guard_q <= guard_q + GW'(1);
              end else if (byte_cnt_q != BW'(BYTES_PER_LINE)) begin
                sym_q       <= slice_d;
                sym_valid_q <= 1'b1;
                sym_cnt_q   <= sym_cnt_q + 2'd1;
                if (sym_cnt_q == 2'd3) begin
                  sym_last_q <= 1'b1;
                  byte_cnt_q <= byte_cnt_q + BW'(1);
                end
              end
            end
          end
        end
        default: state_q <= S_HUNT;
      endcase
    end
  end

  assign frame_start = frame_start_q;

  // -------------------------------------------------------------------------
  // Packer: the shift register is fully overwritten by four new symbols, so
  // leftovers of a discarded partial byte never leak into the next byte.
  // -------------------------------------------------------------------------
  logic [5:0] shift_q;
  logic [7:0] wr_data_q;
  logic       wr_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= 6'd0;
      wr_data_q  <= 8'd0;
      wr_valid_q <= 1'b0;
    end else begin
      wr_valid_q <= sym_valid_q & sym_last_q;
      if (sym_valid_q) begin
        shift_q <= {shift_q[3:0], sym_q};
        if (sym_last_q) wr_data_q <= {shift_q, sym_q};
      end
    end
  end

  // -------------------------------------------------------------------------
  // Show-ahead FIFO
  // -------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;
  logic          fifo_full, fifo_empty, do_wr, do_rd;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // A full FIFO drops the write even if a read happens in the same cycle.
  assign do_wr      = wr_valid_q & ~fifo_full;
  assign do_rd      = ~fifo_empty & out_if.data_ready;

  always_comb begin
    count_d = count_q + CW'(do_wr) - CW'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_valid_q & fifo_full) overflow_q <= 1'b1;
    end
  end

  assign out_if.data_valid = ~fifo_empty;
  assign out_if.data_out   = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign overflow          = overflow_q;

  // -------------------------------------------------------------------------
  // Protection-bit error counter
  // -------------------------------------------------------------------------
`ifdef BT656_ERR_COUNT_EN
  logic [15:0] err_count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= 16'd0;
    end else if ((state_q == S_XY) && !xy_ok && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end
  assign err_count = err_count_q;
`else
  assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_bt656_data_decoder.sv
// ---------------------------------------------------------------------------
// tb_bt656_data_decoder
//   Self-checking bench for bt656_data_decoder. Inputs are driven on the
//   falling edge; expected FIFO bytes are queued when their symbols are sent
//   and compared by a monitor whenever a handshake is about to complete.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bt656_data_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  td_data;
  logic        frame_start;
  logic        overflow;
  logic [15:0] err_count;

  bt656_data_decoder_if bus();

  bt656_data_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .td_data     (td_data),
    .out_if      (bus),
    .frame_start (frame_start),
    .overflow    (overflow),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  int         rx_count = 0;
  int         fs_count = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] y0;
    logic [7:0] y1;
    logic [7:0] y2;
    logic [7:0] y3;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid && ready.
  always @(negedge clk) begin
    #1;
    if (rst === 1'b0 && bus.data_valid === 1'b1 && bus.data_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte actual=%02h required=none", bus.data_out);
      end else begin
        chk("fifo_byte", 32'(bus.data_out), 32'(exp_q.pop_front()));
        rx_count++;
      end
    end
  end

  always @(negedge clk) begin
    if (frame_start === 1'b1) fs_count++;
  end

  // Reference slicer used to pick Y levels for a wanted symbol
  function automatic logic [7:0] sym2y(input logic [1:0] s);
    case (s)
      2'b00:   return 8'd16;
      2'b01:   return 8'd88;
      2'b10:   return 8'd160;
      default: return 8'd232;
    endcase
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    td_data = b;
  endtask

  task automatic send_y(input logic [7:0] y);
    send(8'h80);
    send(y);
  endtask

  task automatic code(input logic [7:0] xy);
    send(8'hFF); send(8'h00); send(8'h00); send(xy);
  endtask

  task automatic guard();
    repeat (8) send_y(8'd200);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit push);
    for (int i = 3; i >= 0; i--) send_y(sym2y(b[2*i +: 2]));
    if (push) exp_q.push_back(b);
  endtask

  task automatic idle(input int n);
    repeat (n) send(8'h10);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      send(8'h10);
      t++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  int rx_base;

  initial begin
    vecs[0] = '{8'd16,  8'd88,  8'd160, 8'd232, 8'h1B};
    vecs[1] = '{8'd51,  8'd52,  8'd123, 8'd124, 8'h16};
    vecs[2] = '{8'd195, 8'd196, 8'd0,   8'd254, 8'hB3};
    vecs[3] = '{8'd232, 8'd160, 8'd88,  8'd16,  8'hE4};
    vecs[4] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'h00};
    vecs[5] = '{8'd254, 8'd254, 8'd254, 8'd254, 8'hFF};
    vecs[6] = '{8'd100, 8'd200, 8'd30,  8'd130, 8'h72};
    vecs[7] = '{8'd52,  8'd124, 8'd196, 8'd51,  8'h6C};

    // ---------------- reset state
    rst = 1'b1;
    td_data = 8'h10;
    bus.data_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.data_ready = 1'b1;

    // ---------------- single byte, latency and frame_start
    code(8'hAB);
    code(8'h80);
    @(posedge clk); #1;
    chk("frame_start_pulse", 32'(frame_start), 32'd1);
    send(8'h80);
    @(posedge clk); #1;
    chk("frame_start_clear", 32'(frame_start), 32'd0);
    send(8'd200);
    repeat (7) send_y(8'd200);
    send_y(8'd16); send_y(8'd88); send_y(8'd160);
    send(8'h80); send(8'd232);
    exp_q.push_back(8'h1B);
    @(posedge clk); #1;
    chk("dv_latency_1", 32'(bus.data_valid), 32'd0);
    send(8'hFF);
    @(posedge clk); #1;
    chk("dv_latency_2", 32'(bus.data_valid), 32'd0);
    send(8'h00);
    @(posedge clk); #1;
    chk("dv_latency_3", 32'(bus.data_valid), 32'd1);
    send(8'h00); send(8'h9D);
    wait_drain("drain_single");

    // ---------------- table-driven slicer vectors
    code(8'h80);
    @(posedge clk); #1;
    chk("frame_start_no_v1", 32'(frame_start), 32'd0);
    guard();
    for (int i = 0; i < 8; i++) begin
      send_y(vecs[i].y0); send_y(vecs[i].y1);
      send_y(vecs[i].y2); send_y(vecs[i].y3);
      exp_q.push_back(vecs[i].exp);
    end
    code(8'h9D);
    wait_drain("drain_table");

    // ---------------- full line, byte limit
    code(8'hB6);
    code(8'h80);
    @(posedge clk); #1;
    chk("frame_start_after_eav_v1", 32'(frame_start), 32'd1);
    rx_base = rx_count;
    guard();
    for (int i = 0; i < 200; i++) send_byte(8'(i) ^ 8'h5A, i < 176);
    code(8'h9D);
    wait_drain("drain_full_line");
    idle(30);
    chk("full_line_count", 32'(rx_count - rx_base), 32'd176);

    // ---------------- bad protection bits
    code(8'h81);
    @(posedge clk); #1;
`ifdef BT656_ERR_COUNT_EN
    chk("err_count_bad_parity", 32'(err_count), 32'd1);
`else
    chk("err_count_bad_parity", 32'(err_count), 32'd0);
`endif
    repeat (16) send_y(8'd232);
    idle(4);
    chk("bad_code_no_data", 32'(bus.data_valid), 32'd0);
    code(8'h00);
    @(posedge clk); #1;
`ifdef BT656_ERR_COUNT_EN
    chk("err_count_bit7", 32'(err_count), 32'd2);
`else
    chk("err_count_bit7", 32'(err_count), 32'd0);
`endif
    repeat (8) send_y(8'd88);
    idle(4);

    // ---------------- overflow
    bus.data_ready = 1'b0;
    code(8'h80);
    guard();
    for (int i = 0; i < 17; i++) send_byte(8'hA0 + 8'(i), i < 16);
    code(8'h9D);
    idle(4);
    chk("overflow_set", 32'(overflow), 32'd1);
    chk("overflow_held_valid", 32'(bus.data_valid), 32'd1);
    chk("overflow_head", 32'(bus.data_out), 32'hA0);
    send(8'h10);
    bus.data_ready = 1'b1;
    wait_drain("drain_overflow");
    idle(10);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // ---------------- EAV mid-byte discards partial byte
    code(8'h80);
    guard();
    send_y(8'd232); send_y(8'd16);
    code(8'h9D);
    idle(6);
    chk("partial_discard", 32'(bus.data_valid), 32'd0);
    code(8'h80);
    guard();
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'h99, 1'b1);
    code(8'h9D);
    wait_drain("drain_after_partial");

    // ---------------- reset mid-line with bytes in the FIFO
    bus.data_ready = 1'b0;
    code(8'h80);
    guard();
    for (int i = 0; i < 5; i++) send_byte(8'h11 * 8'(i + 1), 1'b0);
    send_y(8'd232); send_y(8'd160);
    #1;
    chk("pre_rst_valid", 32'(bus.data_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_mid_overflow", 32'(overflow), 32'd0);
    chk("rst_mid_data_out", 32'(bus.data_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.data_ready = 1'b1;
    repeat (40) send_y(8'd232);
    code(8'h9D);
    idle(6);
    chk("rst_no_resume", 32'(bus.data_valid), 32'd0);
    code(8'h80);
    guard();
    send_byte(8'h5E, 1'b1);
    send_byte(8'hA7, 1'b1);
    code(8'h9D);
    wait_drain("drain_after_rst");
    idle(10);

    chk("frame_start_total", 32'(fs_count), 32'd2);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
